// File: rtl/pixel_packer.sv
// pixel_packer: shades ray-marcher hits to grey and streams them as RGB888 video with frame/line tags.
// surface_point packs {x, y, z} as signed Q16.16 words, x in the top word; only z drives the shade.
module pixel_packer #(
    parameter int          FRAME_W    = 640,
    parameter int          FRAME_H    = 480,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [23:0] BG_COLOR   = 24'h000020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] surface_point,
    input  logic        valid,
    input  logic        hit,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_user,
    output logic        out_last,
    output logic        frame_done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
    localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1;

    logic [31:0]    z;
    logic [7:0]     grey;
    logic [23:0]    shade;
    logic           unused_xy;
    logic           rst_hold_q;
    logic           s1_valid_q;
    logic [23:0]    s1_pix_q;
    logic [23:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    count_q, count_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           frame_done_q, overflow_q;
    logic           pop, push, accept, x_wrap, y_wrap;

    assign z         = surface_point[31:0];
    assign unused_xy = ^surface_point[95:32];
    // Negative z is nearest (white); anything at or beyond 256.0 is black.
    assign grey      = z[31] ? 8'd255 : (|z[30:24] ? 8'd0 : ~z[23:16]);
    assign shade     = hit ? {3{grey}} : BG_COLOR;

    assign out_valid  = count_q != '0;
    assign pop        = out_valid && out_ready;
    assign push       = s1_valid_q;
    assign accept     = push && (count_q != (AW+1)'(FIFO_DEPTH) || pop);
    assign x_wrap     = x_q == XW'(FRAME_W - 1);
    assign y_wrap     = y_q == YW'(FRAME_H - 1);
    assign out_data   = out_valid ? mem_q[rd_q] : '0;
    assign out_user   = out_valid && x_q == '0 && y_q == '0;
    assign out_last   = out_valid && x_wrap;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    always_comb begin
        count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);
        x_d     = pop ? (x_wrap ? '0 : x_q + XW'(1)) : x_q;
        y_d     = pop && x_wrap ? (y_wrap ? '0 : y_q + YW'(1)) : y_q;
    end

    // rst_hold_q masks the first edge after reset release so inputs there are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_hold_q   <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rst_hold_q   <= 1'b0;
            s1_valid_q   <= valid && !rst_hold_q;
            s1_pix_q     <= shade;
            wr_q         <= accept ? wr_q + AW'(1) : wr_q;
            rd_q         <= pop ? rd_q + AW'(1) : rd_q;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= pop && x_wrap && y_wrap;
            overflow_q   <= overflow_q || (push && !accept);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_q] <= s1_pix_q;
    end
endmodule
